// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types, widths and byte-merge helper for data_memory_mp
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_mp_if.sv
// rtl/data_memory_mp_if.sv - CPU, keyboard, display and scrub-control signals of data_memory_mp
interface data_memory_mp_if #(
    parameter int N_RD = 4
);
    import data_mem_pkg::*;

    logic                          we;
    logic [WORD_W-1:0]             a;
    logic [WORD_W-1:0]             wd;
    logic [BE_W-1:0]               be;
    logic [WORD_W-1:0]             rd;
    logic                          we_kb;
    logic [WORD_W-1:0]             addr_kb;
    logic [WORD_W-1:0]             data_kb;
    logic [WORD_W-1:0]             code_key;
    logic [N_RD-1:0][WORD_W-1:0]   rd_addr;
    logic [N_RD-1:0][WORD_W-1:0]   rd_data;
    logic                          clr_req;
    logic                          busy;
    logic                          kb_ovf;
    logic                          oor_err;

    modport master (
        output we, a, wd, be, we_kb, addr_kb, data_kb, rd_addr, clr_req,
        input  rd, code_key, rd_data, busy, kb_ovf, oor_err
    );

    modport slave (
        input  we, a, wd, be, we_kb, addr_kb, data_kb, rd_addr, clr_req,
        output rd, code_key, rd_data, busy, kb_ovf, oor_err
    );

endinterface

// File: rtl/kb_pending_buf.sv
// rtl/kb_pending_buf.sv - one-entry holding buffer for keyboard writes that lose arbitration
module kb_pending_buf
    import data_mem_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              drain,
    input  logic              flush,
    input  logic [AW-1:0]     cap_idx,
    input  logic [WORD_W-1:0] cap_data,
    output logic              valid,
    output logic [AW-1:0]     idx,
    output logic [WORD_W-1:0] data,
    output logic              overwrite
);

    // An entry that is neither drained nor flushed when a new capture arrives is lost.
    assign overwrite = capture & valid & ~drain & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            idx   <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            idx   <= cap_idx;
            data  <= cap_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_memory_mp.sv
// rtl/data_memory_mp.sv - multi-port data RAM with CPU/keyboard write arbitration and scrub engine
module data_memory_mp
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int N_RD  = 4
) (
    input  logic           clk,
    input  logic           rst,
    data_memory_mp_if.slave bus
);

    // Read port order: 0 = CPU, 1 = keyboard, 2.. = display ports.
    localparam int NP = N_RD + 2;

    mem_state_t                state;
    logic [AW-1:0]             cnt;
    logic                      kb_ovf_q;
    logic                      oor_err_q;
    logic [WORD_W-1:0]         mem [DEPTH];

    logic                      pend_valid;
    logic [AW-1:0]             pend_idx;
    logic [WORD_W-1:0]         pend_data;
    logic                      pend_ovw;

    logic [NP-1:0][WORD_W-1:0] p_addr;
    logic [NP-1:0][WORD_W-1:0] p_data;
    logic [NP-1:0]             p_oor;

    logic                      idle;
    logic                      cpu_w;
    logic                      kb_w;
    logic [AW-1:0]             cpu_idx;
    logic [AW-1:0]             kb_idx;
    logic                      wr_en;
    logic [AW-1:0]             wr_idx;
    logic [WORD_W-1:0]         wr_data;
    logic                      capture;
    logic                      drain;
    logic                      flush;

    always_comb begin
        p_addr[0] = bus.a;
        p_addr[1] = bus.addr_kb;
        for (int i = 0; i < N_RD; i++) p_addr[2+i] = bus.rd_addr[i];
    end

    for (genvar g = 0; g < NP; g++) begin : g_port
        logic [AW-1:0] idx;
        logic          unused_lsb;
        assign idx        = p_addr[g][AW+1:2];
        assign unused_lsb = ^p_addr[g][1:0];
        assign p_oor[g]   = |p_addr[g][WORD_W-1:AW+2];
        assign p_data[g]  = (state == CLEAR || p_oor[g]) ? '0 :
                            (pend_valid && pend_idx == idx) ? pend_data : mem[idx];
    end

    always_comb begin
        bus.rd       = p_data[0];
        bus.code_key = p_data[1];
        for (int i = 0; i < N_RD; i++) bus.rd_data[i] = p_data[2+i];
    end

    assign bus.busy    = (state == CLEAR);
    assign bus.kb_ovf  = kb_ovf_q;
    assign bus.oor_err = oor_err_q;

    assign idle    = (state == IDLE);
    assign cpu_w   = idle & bus.we & ~p_oor[0];
    assign kb_w    = idle & bus.we_kb & ~p_oor[1];
    assign cpu_idx = p_addr[0][AW+1:2];
    assign kb_idx  = p_addr[1][AW+1:2];
    assign flush   = idle & bus.clr_req;

    // Single array write port: scrub, then CPU, then pending drain, then direct keyboard.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cnt;
        wr_data = '0;
        capture = 1'b0;
        drain   = 1'b0;
        if (!idle) begin
            wr_en = 1'b1;
        end else if (cpu_w) begin
            wr_en   = 1'b1;
            wr_idx  = cpu_idx;
            wr_data = byte_merge(mem[cpu_idx], bus.wd, bus.be);
            capture = kb_w;
        end else if (pend_valid) begin
            wr_en   = 1'b1;
            wr_idx  = pend_idx;
            wr_data = pend_data;
            drain   = 1'b1;
            capture = kb_w;
        end else if (kb_w) begin
            wr_en   = 1'b1;
            wr_idx  = kb_idx;
            wr_data = bus.data_kb;
        end
    end

    kb_pending_buf #(.AW(AW)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .drain     (drain),
        .flush     (flush),
        .cap_idx   (kb_idx),
        .cap_data  (bus.data_kb),
        .valid     (pend_valid),
        .idx       (pend_idx),
        .data      (pend_data),
        .overwrite (pend_ovw)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            kb_ovf_q  <= 1'b0;
            oor_err_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (bus.clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
            if (pend_ovw) kb_ovf_q  <= 1'b1;
            if (|p_oor)   oor_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_memory_mp.sv
// tb/tb_data_memory_mp.sv - scoreboard bench for data_memory_mp
module tb_data_memory_mp;

    localparam int S_RD   = 0;
    localparam int S_KEY  = 1;
    localparam int S_DISP = 2;
    localparam int S_BUSY = 6;
    localparam int S_OVF  = 7;
    localparam int S_OOR  = 8;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    data_memory_mp_if #(.N_RD(4)) bus ();

    data_memory_mp #(.DEPTH(64), .N_RD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_RD:            return bus.rd;
            S_KEY:           return bus.code_key;
            2, 3, 4, 5:      return bus.rd_data[sel-2];
            S_BUSY:          return {31'b0, bus.busy};
            S_OVF:           return {31'b0, bus.kb_ovf};
            S_OOR:           return {31'b0, bus.oor_err};
            default:         return 32'hxxxxxxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = observe(e.sel);
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s: actual=%h required=%h (cycle %0d)", e.name, act, e.exp, e.cyc);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v, input string name);
        sb.push_back('{cyc, sel, v, name});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we      = 1'b0;
        bus.a       = '0;
        bus.wd      = '0;
        bus.be      = '0;
        bus.we_kb   = 1'b0;
        bus.addr_kb = '0;
        bus.data_kb = '0;
        bus.rd_addr = '0;
        bus.clr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk(S_BUSY, 1, "reset_busy");
        chk(S_OVF, 0, "reset_kb_ovf");
        chk(S_OOR, 0, "reset_oor_err");
        rst = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk(S_BUSY, 1, "init_scrub_busy");
            chk(S_RD, 0, "init_scrub_rd");
            step();
        end
        chk(S_BUSY, 0, "init_scrub_done");
        chk(S_RD, 0, "rd_addr_00");
        for (int i = 0; i < 4; i++) chk(S_DISP + i, 0, "rd_data_00");
        step();
        bus.a = 32'hFC;
        for (int i = 0; i < 4; i++) bus.rd_addr[i] = 32'hFC;
        chk(S_RD, 0, "rd_addr_fc");
        for (int i = 0; i < 4; i++) chk(S_DISP + i, 0, "rd_data_fc");
        step();

        // byte-enable merge
        bus.we = 1'b1; bus.a = 32'h10; bus.wd = 32'hDEADBEEF; bus.be = 4'b0101;
        step();
        bus.we = 1'b0;
        chk(S_RD, 32'h00AD00EF, "be_merge");
        step();

        // same-cycle CPU and keyboard write
        bus.we = 1'b1; bus.a = 32'h20; bus.wd = 32'h11111111; bus.be = 4'hF;
        bus.we_kb = 1'b1; bus.addr_kb = 32'h24; bus.data_kb = 32'h22222222;
        step();
        bus.we = 1'b0; bus.we_kb = 1'b0;
        bus.rd_addr[0] = 32'h24;
        chk(S_KEY, 32'h22222222, "kb_forward_key");
        chk(S_DISP, 32'h22222222, "kb_forward_disp");
        chk(S_RD, 32'h11111111, "cpu_win_rd");
        step();
        chk(S_KEY, 32'h22222222, "kb_drained_key");
        chk(S_DISP, 32'h22222222, "kb_drained_disp");
        step();

        // pending overwrite under continuous CPU writes
        bus.we = 1'b1; bus.be = 4'hF; bus.we_kb = 1'b1;
        bus.a = 32'h40; bus.wd = 32'hA0; bus.addr_kb = 32'h30; bus.data_kb = 32'hB0;
        chk(S_OVF, 0, "ovf_c1");
        step();
        bus.a = 32'h44; bus.wd = 32'hA1; bus.addr_kb = 32'h34; bus.data_kb = 32'hB1;
        chk(S_OVF, 0, "ovf_c2");
        step();
        bus.a = 32'h48; bus.wd = 32'hA2; bus.addr_kb = 32'h38; bus.data_kb = 32'hB2;
        chk(S_OVF, 1, "ovf_c3");
        step();
        bus.we = 1'b0; bus.we_kb = 1'b0;
        bus.rd_addr[0] = 32'h30; bus.rd_addr[1] = 32'h34;
        bus.rd_addr[2] = 32'h38; bus.rd_addr[3] = 32'h40;
        chk(S_RD, 32'hA2, "ovf_cpu_last");
        chk(S_KEY, 32'hB2, "ovf_fwd_key");
        chk(S_DISP + 0, 0, "ovf_lost_30");
        chk(S_DISP + 1, 0, "ovf_lost_34");
        chk(S_DISP + 2, 32'hB2, "ovf_fwd_38");
        chk(S_DISP + 3, 32'hA0, "ovf_cpu_first");
        step();
        chk(S_DISP + 2, 32'hB2, "ovf_array_38");
        chk(S_DISP + 0, 0, "ovf_array_30");
        chk(S_OVF, 1, "ovf_sticky");
        step();

        // direct keyboard write with nothing pending
        bus.we_kb = 1'b1; bus.addr_kb = 32'h50; bus.data_kb = 32'h55;
        step();
        bus.we_kb = 1'b0;
        chk(S_KEY, 32'h55, "kb_direct");
        step();

        // out-of-range CPU write must not alias onto word 0
        bus.we = 1'b1; bus.a = 32'h100; bus.wd = 32'hFFFFFFFF; bus.be = 4'hF;
        chk(S_RD, 0, "oor_rd_zero");
        chk(S_OOR, 0, "oor_not_yet");
        step();
        bus.we = 1'b0; bus.a = 32'h0;
        chk(S_RD, 0, "oor_no_alias");
        chk(S_OOR, 1, "oor_set");
        step();
        step();
        chk(S_OOR, 1, "oor_sticky");
        step();

        // scrub on request with a dropped late write
        bus.clr_req = 1'b1;
        chk(S_BUSY, 0, "clr_req_cycle");
        step();
        bus.clr_req = 1'b0;
        bus.rd_addr[0] = 32'h10; bus.rd_addr[1] = 32'h24;
        for (int k = 0; k < 64; k++) begin
            if (k == 62) begin
                bus.we = 1'b1; bus.a = 32'h60; bus.wd = 32'h77; bus.be = 4'hF;
                bus.we_kb = 1'b1; bus.addr_kb = 32'h64; bus.data_kb = 32'h88;
            end
            if (k == 63) begin
                bus.we = 1'b0; bus.we_kb = 1'b0;
            end
            chk(S_BUSY, 1, "clr_busy");
            chk(S_DISP, 0, "clr_disp_zero");
            step();
        end
        bus.a = 32'h60; bus.addr_kb = 32'h64;
        bus.rd_addr[2] = 32'h38; bus.rd_addr[3] = 32'h20;
        chk(S_BUSY, 0, "clr_done");
        chk(S_RD, 0, "clr_cpu_dropped");
        chk(S_KEY, 0, "clr_kb_dropped");
        for (int i = 0; i < 4; i++) chk(S_DISP + i, 0, "clr_words_zero");
        chk(S_OVF, 1, "clr_ovf_kept");
        chk(S_OOR, 1, "clr_oor_kept");
        step();
        step();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: actual=%0d required=0 pending expectations", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
